// File: rtl/flag_pkg.sv
// Shared types for the C/Z flag context unit: branch condition codes and the
// flag pair that is stored, stacked and restored as one unit.
package flag_pkg;

  typedef enum logic [1:0] {
    BRCC = 2'b00,
    BRCS = 2'b01,
    BRNE = 2'b10,
    BREQ = 2'b11
  } cond_t;

  typedef struct packed {
    logic c;
    logic z;
  } flags_t;

  // True when the branch condition holds for the given flag pair.
  function automatic logic cond_eval(input cond_t cond, input flags_t f);
    logic hit;
    hit = 1'b0;
    case (cond)
      BRCC:    hit = ~f.c;
      BRCS:    hit = f.c;
      BRNE:    hit = ~f.z;
      BREQ:    hit = f.z;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/flag_shadow_stack.sv
// LIFO of saved flag pairs for nested interrupts. Only the occupancy count is
// reset; entry storage is don't-care until written.
module flag_shadow_stack
  import flag_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         RST,
  input  logic                         push,
  input  logic                         pop,
  input  flags_t                       din,
  output flags_t                       dout,
  output logic [$clog2(DEPTH+1)-1:0]   cnt,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  flags_t          mem [DEPTH];
  logic [CW-1:0]   cnt_q;
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   rd_idx;
  logic            do_push;
  logic            do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign wr_idx  = AW'(cnt_q);
  assign rd_idx  = AW'(cnt_q - CW'(1));

  // A simultaneous push and pop cancel out; overflowing pushes and empty pops are dropped.
  assign do_push = push && !pop && !full;
  assign do_pop  = pop && !push && !empty;

  assign dout    = empty ? flags_t'(2'b00) : mem[rd_idx];
  assign cnt     = cnt_q;

  always_ff @(posedge clk) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (do_push) begin
      cnt_q <= cnt_q + CW'(1);
    end else if (do_pop) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/flag_context_unit.sv
// Live C/Z flag registers with ALU load, SEC/CLC, interrupt save/restore via a
// shadow stack, sticky stack error flags and the branch-taken decision.
module flag_context_unit
  import flag_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         RST,
  input  logic                         C_IN,
  input  logic                         Z_IN,
  input  logic                         FLG_C_LD,
  input  logic                         FLG_Z_LD,
  input  logic                         FLG_C_SET,
  input  logic                         FLG_C_CLR,
  input  logic                         FLG_SAVE,
  input  logic                         FLG_RESTORE,
  input  logic [1:0]                   COND,
  input  logic                         COND_VALID,
  output logic                         C_FLAG,
  output logic                         Z_FLAG,
  output logic                         BR_TAKEN,
  output logic [$clog2(DEPTH+1)-1:0]   SHAD_CNT,
  output logic                         SHAD_OVF,
  output logic                         SHAD_UNF
);

  flags_t flags_q;
  flags_t flags_nxt;
  flags_t stk_dout;
  logic   ovf_q;
  logic   ovf_nxt;
  logic   unf_q;
  logic   unf_nxt;
  logic   stk_full;
  logic   stk_empty;

  flag_shadow_stack #(
    .DEPTH (DEPTH)
  ) u_stack (
    .clk   (clk),
    .RST   (RST),
    .push  (FLG_SAVE),
    .pop   (FLG_RESTORE),
    .din   (flags_q),
    .dout  (stk_dout),
    .cnt   (SHAD_CNT),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // Next-state priority: restore overrides all live updates; save+restore is a no-op.
  always_comb begin
    flags_nxt = flags_q;
    ovf_nxt   = ovf_q;
    unf_nxt   = unf_q;

    if (FLG_SAVE && FLG_RESTORE) begin
      flags_nxt = flags_q;
    end else if (FLG_RESTORE) begin
      if (stk_empty) begin
        flags_nxt = flags_t'(2'b00);
        unf_nxt   = 1'b1;
      end else begin
        flags_nxt = stk_dout;
      end
    end else begin
      if (FLG_C_CLR) begin
        flags_nxt.c = 1'b0;
      end else if (FLG_C_SET) begin
        flags_nxt.c = 1'b1;
      end else if (FLG_C_LD) begin
        flags_nxt.c = C_IN;
      end

      if (FLG_Z_LD) begin
        flags_nxt.z = Z_IN;
      end

      if (FLG_SAVE && stk_full) begin
        ovf_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      flags_q <= flags_t'(2'b00);
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      flags_q <= flags_nxt;
      ovf_q   <= ovf_nxt;
      unf_q   <= unf_nxt;
    end
  end

  assign C_FLAG   = flags_q.c;
  assign Z_FLAG   = flags_q.z;
  assign SHAD_OVF = ovf_q;
  assign SHAD_UNF = unf_q;

  // Branch decision reads only the registered flags, never the ALU inputs.
  assign BR_TAKEN = COND_VALID & cond_eval(cond_t'(COND), flags_q);

endmodule

// File: tb/tb_flag_context_unit.sv
// Directed bench for flag_context_unit with hand-computed expectations.
module tb_flag_context_unit;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          RST;
  logic          C_IN, Z_IN;
  logic          FLG_C_LD, FLG_Z_LD, FLG_C_SET, FLG_C_CLR;
  logic          FLG_SAVE, FLG_RESTORE;
  logic [1:0]    COND;
  logic          COND_VALID;
  logic          C_FLAG, Z_FLAG, BR_TAKEN;
  logic [CW-1:0] SHAD_CNT;
  logic          SHAD_OVF, SHAD_UNF;

  int checks   = 0;
  int failures = 0;

  flag_context_unit #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .RST         (RST),
    .C_IN        (C_IN),
    .Z_IN        (Z_IN),
    .FLG_C_LD    (FLG_C_LD),
    .FLG_Z_LD    (FLG_Z_LD),
    .FLG_C_SET   (FLG_C_SET),
    .FLG_C_CLR   (FLG_C_CLR),
    .FLG_SAVE    (FLG_SAVE),
    .FLG_RESTORE (FLG_RESTORE),
    .COND        (COND),
    .COND_VALID  (COND_VALID),
    .C_FLAG      (C_FLAG),
    .Z_FLAG      (Z_FLAG),
    .BR_TAKEN    (BR_TAKEN),
    .SHAD_CNT    (SHAD_CNT),
    .SHAD_OVF    (SHAD_OVF),
    .SHAD_UNF    (SHAD_UNF)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    RST = 1'b0; C_IN = 1'b0; Z_IN = 1'b0;
    FLG_C_LD = 1'b0; FLG_Z_LD = 1'b0; FLG_C_SET = 1'b0; FLG_C_CLR = 1'b0;
    FLG_SAVE = 1'b0; FLG_RESTORE = 1'b0;
  endtask

  // Advance one clock edge; inputs are then cleared and outputs sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic do_reset();
    idle_inputs();
    RST = 1'b1;
    step();
  endtask

  task automatic load(input logic c, input logic z);
    C_IN = c; Z_IN = z; FLG_C_LD = 1'b1; FLG_Z_LD = 1'b1;
  endtask

  task automatic check_flags(input string tag, input int c, input int z);
    check({tag, ".C"}, int'(C_FLAG), c);
    check({tag, ".Z"}, int'(Z_FLAG), z);
  endtask

  task automatic check_br(input string tag, input logic [1:0] cond, input logic vld, input int exp);
    COND = cond; COND_VALID = vld;
    #1;
    check(tag, int'(BR_TAKEN), exp);
  endtask

  initial begin
    COND = 2'b00; COND_VALID = 1'b0;
    #2;

    // Reset state
    do_reset();
    check_flags("rst", 0, 0);
    check("rst.cnt", int'(SHAD_CNT), 0);
    check("rst.ovf", int'(SHAD_OVF), 0);
    check("rst.unf", int'(SHAD_UNF), 0);
    check_br("rst.brcc", 2'b00, 1'b1, 1);
    check_br("rst.breq", 2'b11, 1'b1, 0);

    // Load and branch
    load(1'b1, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      check_flags($sformatf("hold%0d", i), 1, 0);
      step();
    end
    check_br("ld.brcs", 2'b01, 1'b1, 1);
    check_br("ld.breq", 2'b11, 1'b1, 0);
    check_br("ld.brne", 2'b10, 1'b1, 1);
    check_br("ld.brcc", 2'b00, 1'b1, 0);
    check_br("ld.novalid", 2'b01, 1'b0, 0);
    // Branch must ignore ALU inputs
    Z_IN = 1'b1; C_IN = 1'b0;
    check_br("ld.ignore_in", 2'b11, 1'b1, 0);
    idle_inputs();

    // Nested save/restore
    do_reset();
    load(1'b1, 1'b0); step();
    FLG_SAVE = 1'b1; step();
    load(1'b0, 1'b1); step();
    FLG_SAVE = 1'b1; step();
    check("nest.cnt2", int'(SHAD_CNT), 2);
    load(1'b1, 1'b1); step();
    check_flags("nest.live", 1, 1);
    FLG_RESTORE = 1'b1; step();
    check_flags("nest.r1", 0, 1);
    check("nest.cnt1", int'(SHAD_CNT), 1);
    FLG_RESTORE = 1'b1; step();
    check_flags("nest.r2", 1, 0);
    check("nest.cnt0", int'(SHAD_CNT), 0);
    check("nest.ovf", int'(SHAD_OVF), 0);
    check("nest.unf", int'(SHAD_UNF), 0);

    // Overflow: entries pushed are pattern i = {c=i[0], z=i[1]} for i=0..3
    do_reset();
    for (int i = 0; i < 5; i++) begin
      load(1'((i >> 0) & 1), 1'((i >> 1) & 1)); step();
      FLG_SAVE = 1'b1; step();
      if (i == 3) begin
        check("ovf.cnt4", int'(SHAD_CNT), 4);
        check("ovf.pre", int'(SHAD_OVF), 0);
      end
    end
    check("ovf.cnt", int'(SHAD_CNT), 4);
    check("ovf.flag", int'(SHAD_OVF), 1);
    for (int i = 3; i >= 0; i--) begin
      FLG_RESTORE = 1'b1; step();
      check_flags($sformatf("ovf.pop%0d", i), (i >> 0) & 1, (i >> 1) & 1);
      check($sformatf("ovf.popcnt%0d", i), int'(SHAD_CNT), i);
    end
    check("ovf.sticky", int'(SHAD_OVF), 1);
    check("ovf.nounf", int'(SHAD_UNF), 0);

    // Underflow
    do_reset();
    load(1'b1, 1'b1); step();
    FLG_RESTORE = 1'b1; step();
    check_flags("unf", 0, 0);
    check("unf.flag", int'(SHAD_UNF), 1);
    check("unf.cnt", int'(SHAD_CNT), 0);
    step();
    check("unf.sticky", int'(SHAD_UNF), 1);

    // SAVE+RESTORE together with one entry stacked
    do_reset();
    load(1'b1, 1'b0); FLG_SAVE = 1'b1; step();
    check("sr.cnt_pre", int'(SHAD_CNT), 1);
    check_flags("sr.pre", 1, 0);
    load(1'b0, 1'b1); FLG_C_SET = 1'b1; FLG_SAVE = 1'b1; FLG_RESTORE = 1'b1; step();
    check("sr.cnt", int'(SHAD_CNT), 1);
    check_flags("sr.live", 1, 0);
    check("sr.ovf", int'(SHAD_OVF), 0);
    check("sr.unf", int'(SHAD_UNF), 0);
    load(1'b1, 1'b1); step();
    FLG_RESTORE = 1'b1; step();
    check_flags("sr.pop", 0, 0);

    // SAVE stacks pre-edge C while the load updates live C
    do_reset();
    C_IN = 1'b1; FLG_C_LD = 1'b1; FLG_SAVE = 1'b1; step();
    check("sl.live", int'(C_FLAG), 1);
    check("sl.cnt", int'(SHAD_CNT), 1);
    FLG_RESTORE = 1'b1; step();
    check("sl.stacked", int'(C_FLAG), 0);

    // SEC/CLC priority
    FLG_C_SET = 1'b1; step();
    check("sec", int'(C_FLAG), 1);
    FLG_C_SET = 1'b1; FLG_C_CLR = 1'b1; step();
    check("sec_clc", int'(C_FLAG), 0);
    C_IN = 1'b0; FLG_C_LD = 1'b1; FLG_C_SET = 1'b1; step();
    check("sec_over_ld", int'(C_FLAG), 1);
    C_IN = 1'b1; FLG_C_LD = 1'b1; FLG_C_CLR = 1'b1; step();
    check("clc_over_ld", int'(C_FLAG), 0);

    // Reset during a restore with three entries stacked
    do_reset();
    FLG_RESTORE = 1'b1; step();
    load(1'b1, 1'b1); step();
    for (int i = 0; i < 3; i++) begin
      FLG_SAVE = 1'b1; step();
    end
    check("mid.cnt3", int'(SHAD_CNT), 3);
    check("mid.unf_pre", int'(SHAD_UNF), 1);
    RST = 1'b1; FLG_RESTORE = 1'b1; step();
    check_flags("mid", 0, 0);
    check("mid.cnt", int'(SHAD_CNT), 0);
    check("mid.ovf", int'(SHAD_OVF), 0);
    check("mid.unf", int'(SHAD_UNF), 0);
    check_br("mid.breq", 2'b11, 1'b1, 0);
    check_br("mid.brcc", 2'b00, 1'b1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flag_context_unit.md
# flag_context_unit

Owns the processor's C and Z status flags end to end. It captures ALU flag results and SEC/CLC updates, and saves and restores flag context across nested interrupts through a parameterised shadow stack. It is also the flag reader: it evaluates branch conditions for the control unit. It sits between the ALU flag outputs and the control unit's branch/interrupt sequencing.

## Interface
- DEPTH, 4: shadow stack entries, i.e. the maximum interrupt nesting depth; must be ≥1.
- clk  in  1  system clock; all state updates on its rising edge.
- RST  in  1  synchronous, active-high reset.
- C_IN  in  1  carry result from the ALU.
- Z_IN  in  1  zero result from the ALU.
- FLG_C_LD  in  1  load C from C_IN.
- FLG_Z_LD  in  1  load Z from Z_IN.
- FLG_C_SET  in  1  force C=1 (SEC).
- FLG_C_CLR  in  1  force C=0 (CLC).
- FLG_SAVE  in  1  push {C,Z} onto the shadow stack (interrupt acknowledge).
- FLG_RESTORE  in  1  pop the shadow stack into {C,Z} (RETID/RETIE).
- COND  in  2  branch condition: 00 BRCC, 01 BRCS, 10 BRNE, 11 BREQ.
- COND_VALID  in  1  current instruction is a conditional branch.
- C_FLAG  out  1  live carry flag.
- Z_FLAG  out  1  live zero flag.
- BR_TAKEN  out  1  branch-taken decision.
- SHAD_CNT  out  $clog2(DEPTH+1)  number of occupied stack entries.
- SHAD_OVF  out  1  sticky: a save was attempted while the stack was full.
- SHAD_UNF  out  1  sticky: a restore was attempted while the stack was empty.

## Operation
- Live flags hold their value when no update is asserted. They are never implicitly cleared.
- C update priority, highest first: RST, RESTORE, C_CLR, C_SET, C_LD. Simultaneous C_SET and C_CLR resolves to C=0.
- Z update priority, highest first: RST, RESTORE, Z_LD.
- SAVE pushes the pre-edge {C,Z}. Loads asserted in the same cycle still update the live flags. The stack entry holds the old values.
- RESTORE with SHAD_CNT>0: live {C,Z} take the top entry and SHAD_CNT decrements. All loads and set/clear in that cycle are ignored.
- RESTORE with SHAD_CNT==0: live flags are cleared to 0, SHAD_UNF is set, and SHAD_CNT stays 0.
- SAVE with SHAD_CNT==DEPTH: the push is dropped, the contents are unchanged, and SHAD_OVF is set. Live-flag loads still apply.
- SAVE and RESTORE in the same cycle: the stack and SHAD_CNT are unchanged and no error flag is set. Live flags are unchanged, and loads and set/clear are ignored.
- BR_TAKEN = COND_VALID and (cond): BRCC !C, BRCS C, BRNE !Z, BREQ Z. It is evaluated combinationally from the registered C_FLAG/Z_FLAG, never from C_IN/Z_IN.
- SHAD_OVF and SHAD_UNF are cleared only by RST.

## Timing
- Reset values: C_FLAG=0, Z_FLAG=0, SHAD_CNT=0, SHAD_OVF=0, SHAD_UNF=0. BR_TAKEN therefore follows COND/COND_VALID against zero flags.
- Stack entry contents are don't-care after reset. Reset does not clear the storage array.
- Flag loads and set/clear: visible on C_FLAG/Z_FLAG one cycle after the asserting edge.
- SAVE: SHAD_CNT increments at the edge; the entry is readable by a RESTORE in the very next cycle.
- RESTORE: restored flags and the decremented SHAD_CNT are visible one cycle later.
- BR_TAKEN: zero-cycle combinational path from COND/COND_VALID and the flag registers.
- RST asserted mid-sequence (e.g. in the same cycle as SAVE or RESTORE) wins unconditionally. All outputs return to reset values at that edge.

## Structure
- Shared package flag_pkg:
  - cond_t enum {BRCC=2'b00, BRCS=2'b01, BRNE=2'b10, BREQ=2'b11}.
  - flags_t packed struct {logic c; logic z;}.
- Sub-module flag_shadow_stack #(DEPTH):
  - Inputs: clk, RST, push, pop, din(flags_t).
  - Outputs: dout(flags_t), cnt, full, empty.
  - Holds the LIFO array and pointer.
  - Leaves the error-flag and live-flag priority logic to the top level.

## Test plan
- Load and branch: RST; drive C_IN=1, Z_IN=0 with FLG_C_LD=FLG_Z_LD=1 for one cycle, then idle 3 cycles. Required: C_FLAG=1, Z_FLAG=0 held for all 3 cycles. BR_TAKEN=1 for COND=01 with COND_VALID=1, and 0 for COND=11.
- Nested save/restore (DEPTH=4):
  - Set {C,Z}={1,0} and SAVE.
  - Load {0,1} and SAVE; SHAD_CNT=2.
  - Load {1,1}, then RESTORE twice.
  - Required: {0,1}, then {1,0}; SHAD_CNT=0; no error flags.
- Overflow: 5 consecutive SAVEs with DEPTH=4. Required: SHAD_CNT=4 and SHAD_OVF=1 after the 5th. Four RESTOREs then return entries 4..1 in LIFO order.
- Underflow: RESTORE from reset with flags {1,1}. Required: flags become {0,0}, SHAD_UNF=1, SHAD_CNT=0.
- Simultaneous events:
  - SAVE+RESTORE with SHAD_CNT=1: the count stays 1 and the flags are unchanged.
  - SAVE+C_LD(C_IN=1) from C=0: the stacked C is 0 and the live C is 1.
  - C_SET+C_CLR: C=0.
- Reset mid-operation: RST asserted in the same cycle as RESTORE with SHAD_CNT=3. Required: next cycle all outputs are at reset values and SHAD_CNT=0.
